adc_sample_sequencer: RTL and testbench

Periodic conversion sequencer and sample buffer sitting directly downstream of the 12-bit PIC-mode ADC reader. The reader performs one conversion after each reset and then parks with its step counter at 22. This block re-arms the reader by pulsing its active-low reset at a programmable rate and detects conversion completion from the step counter. It captures the finished 12-bit sample into a FIFO and presents it to the data collector over a valid/ready stream.

---
 rtl/adc_pkg.sv | 15 +
 rtl/sample_fifo.sv | 58 +++++
 rtl/adc_sample_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC sample sequencer.
package adc_pkg;

  localparam int         ADC_W      = 12;
  localparam logic [6:0] CNT20_DONE = 7'd22;
  localparam int         CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTART = 2'd1,
    ST_CONVERT = 2'd2,
    ST_CAPTURE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO with synchronous active-low reset; head is always on rd_data.
module sample_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    cnt_r;
  logic             push_s;
  logic             pop_s;

  assign full    = (cnt_r == FULL_CNT);
  assign empty   = (cnt_r == {CW{1'b0}});
  assign push_s  = wr_en && !full;
  assign pop_s   = rd_en && !empty;
  assign rd_data = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; memory is cleared so the head reads zero after reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Re-arms the ADC reader at a fixed rate, captures each finished sample into a FWFT FIFO.
// Build option SAMPLE_AVG_EN: write the average of the last four samples instead of the raw one.
module adc_sample_sequencer
  import adc_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int SAMPLE_PERIOD = 50000,
  parameter int RST_CYCLES    = 4,
  parameter int TIMEOUT       = 12000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             adc_rst,
  input  logic [6:0]       cnt20,
  input  logic [ADC_W-1:0] sample,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ADC_W-1:0] out_data,
  output logic             overflow,
  output logic             timeout_err,
  output logic [CNT_W-1:0] sample_count
);

  localparam int TMR_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int PER_W   = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT - 1);

  seq_state_t       state_r;
  seq_state_t       state_s;
  logic [PER_W-1:0] per_r;
  logic [TMR_W-1:0] tmr_r;
  logic             tick_s;
  logic             timeout_hit_s;
  logic             capture_s;
  logic             adc_rst_r;
  logic             timeout_r;
  logic             overflow_r;
  logic [CNT_W-1:0] count_r;
  logic             wr_en_s;
  logic             drop_s;
  logic [ADC_W-1:0] wr_data_s;
  logic             full_s;
  logic             empty_s;

  assign tick_s    = enable && (per_r == PER_LAST);
  assign capture_s = (state_r == ST_CAPTURE);

  // Free-running period counter, parked at zero while starts are not permitted
  always_ff @(posedge clk) begin
    if (!rst) begin
      per_r <= {PER_W{1'b0}};
    end else if (!enable || (per_r == PER_LAST)) begin
      per_r <= {PER_W{1'b0}};
    end else begin
      per_r <= per_r + PER_W'(1);
    end
  end

  // Next-state decode; a tick seen outside IDLE is simply dropped
  always_comb begin
    state_s       = state_r;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s) state_s = ST_RESTART;
        else        state_s = ST_IDLE;
      end
      ST_RESTART: begin
        if (tmr_r == RST_LAST) state_s = ST_CONVERT;
        else                   state_s = ST_RESTART;
      end
      ST_CONVERT: begin
        if (cnt20 == CNT20_DONE) begin
          state_s = ST_CAPTURE;
        end else if (tmr_r == TO_LAST) begin
          state_s       = ST_IDLE;
          timeout_hit_s = 1'b1;
        end else begin
          state_s = ST_CONVERT;
        end
      end
      ST_CAPTURE: state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // State register, per-phase timer and registered reader reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      tmr_r     <= {TMR_W{1'b0}};
      adc_rst_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if ((state_s != state_r) || (state_r == ST_IDLE)) begin
        tmr_r <= {TMR_W{1'b0}};
      end else begin
        tmr_r <= tmr_r + TMR_W'(1);
      end
      adc_rst_r <= (state_s != ST_RESTART);
      if (timeout_hit_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

`ifdef SAMPLE_AVG_EN
  localparam int SUM_W = ADC_W + 2;

  logic [ADC_W-1:0] hist_r [3];
  logic [1:0]       fill_r;
  logic [SUM_W-1:0] sum_s;
  logic             primed_s;

  assign primed_s  = (fill_r == 2'd3);
  assign sum_s     = SUM_W'(sample) + SUM_W'(hist_r[0]) + SUM_W'(hist_r[1]) + SUM_W'(hist_r[2]);
  assign wr_data_s = ADC_W'(sum_s >> 2);
  assign wr_en_s   = capture_s && primed_s && !full_s;
  assign drop_s    = capture_s && primed_s && full_s;

  // Sample history; nothing is written until three earlier samples exist
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_r[0] <= {ADC_W{1'b0}};
      hist_r[1] <= {ADC_W{1'b0}};
      hist_r[2] <= {ADC_W{1'b0}};
      fill_r    <= 2'd0;
    end else if (capture_s) begin
      hist_r[0] <= sample;
      hist_r[1] <= hist_r[0];
      hist_r[2] <= hist_r[1];
      if (!primed_s) begin
        fill_r <= fill_r + 2'd1;
      end
    end
  end
`else
  assign wr_data_s = sample;
  assign wr_en_s   = capture_s && !full_s;
  assign drop_s    = capture_s && full_s;
`endif

  // Capture bookkeeping: write counter and sticky drop flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        count_r <= count_r + CNT_W'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  sample_fifo #(
    .WIDTH (ADC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_data (wr_data_s),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign out_valid    = !empty_s;
  assign adc_rst      = adc_rst_r;
  assign timeout_err  = timeout_r;
  assign overflow     = overflow_r;
  assign sample_count = count_r;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Bench for adc_sample_sequencer: behavioural ADC reader, timestamp-based reference model, per-cycle compare.
module tb_adc_sample_sequencer;
  import adc_pkg::*;

  localparam int P     = 400;
  localparam int RSTC  = 4;
  localparam int TO    = 300;
  localparam int DEPTH = 16;
  localparam int STEP  = 10;
  localparam int CONV  = 22 * STEP;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             adc_rst;
  logic [6:0]       cnt20;
  logic [ADC_W-1:0] sample;
  logic             out_valid;
  logic             out_ready;
  logic [ADC_W-1:0] out_data;
  logic             overflow;
  logic             timeout_err;
  logic [CNT_W-1:0] sample_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] vals[$];
  bit          rand_vals = 1'b0;
  bit          hang      = 1'b0;

  always #5 clk = ~clk;

  adc_sample_sequencer #(
    .DEPTH         (DEPTH),
    .SAMPLE_PERIOD (P),
    .RST_CYCLES    (RSTC),
    .TIMEOUT       (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .adc_rst      (adc_rst),
    .cnt20        (cnt20),
    .sample       (sample),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .overflow     (overflow),
    .timeout_err  (timeout_err),
    .sample_count (sample_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic sig_sel(input int which);
    case (which)
      0:       return adc_rst;
      1:       return out_valid;
      default: return timeout_err;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic lvl, input int bound, input string name, output int n);
    n = 0;
    while (sig_sel(which) !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sig_sel(which) !== lvl) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: level %0b not reached within %0d cycles", name, lvl, bound);
    end
  endtask

  // Behavioural ADC reader: held at step 0 in reset, counts 22 steps of STEP cycles, then parks at 22
  initial begin : reader
    int rd_t;
    bit prev;
    rd_t = 0;
    prev = 1'b1;
    cnt20 = 7'd0;
    sample = 12'hA5C;
    forever begin
      @(negedge clk);
      if (adc_rst !== 1'b1) begin
        if (prev) begin
          if (vals.size() > 0) sample = vals.pop_front();
          else if (rand_vals)  sample = 12'($urandom_range(0, 4095));
        end
        rd_t  = 0;
        cnt20 = 7'd0;
        prev  = 1'b0;
      end else begin
        prev = 1'b1;
        if (rd_t < CONV) rd_t++;
        cnt20 = hang ? 7'd5 : ((rd_t >= CONV) ? 7'd22 : 7'(rd_t / STEP));
      end
    end
  end

  // Reference model: conversions tracked as timestamps, FIFO as a queue
  int          cyc = 0;
  int          m_per;
  bit          m_busy;
  int          m_conv_from;
  int          m_cap_at;
  logic [11:0] mq[$];
  logic [11:0] hist[$];
  logic [15:0] m_count;
  bit          m_ovf, m_to, m_adc_rst, m_zero_head;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin : model
    bit          tick, full, push, take;
    logic [11:0] wv;
    int          s;
    cyc++;
    if (!rst) begin
      m_per = 0; m_busy = 1'b0; m_cap_at = -1; m_conv_from = 0;
      mq.delete(); hist.delete();
      m_count = 16'd0; m_ovf = 1'b0; m_to = 1'b0; m_adc_rst = 1'b0; m_zero_head = 1'b1;
    end else begin
      tick  = enable && (m_per == P - 1);
      m_per = enable ? ((m_per == P - 1) ? 0 : m_per + 1) : 0;
      full  = (mq.size() == DEPTH);
      push  = 1'b0;
      wv    = 12'd0;
      if (!m_busy) begin
        if (tick) begin
          m_busy = 1'b1; m_conv_from = cyc + 1 + RSTC; m_cap_at = -1;
        end
      end else if (m_cap_at == cyc) begin
        m_busy = 1'b0;
`ifdef SAMPLE_AVG_EN
        take = (hist.size() == 3);
        if (take) begin
          s  = int'(sample) + int'(hist[0]) + int'(hist[1]) + int'(hist[2]);
          wv = 12'(s >> 2);
          void'(hist.pop_front());
        end
        hist.push_back(sample);
`else
        take = 1'b1;
        wv   = sample;
`endif
        if (take) begin
          if (full) m_ovf = 1'b1;
          else      push  = 1'b1;
        end
      end else if (cyc >= m_conv_from) begin
        if (cnt20 == 7'd22) m_cap_at = cyc + 1;
        else if (cyc - m_conv_from == TO - 1) begin
          m_to = 1'b1; m_busy = 1'b0;
        end
      end
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (push) begin
        mq.push_back(wv); m_count++; m_zero_head = 1'b0;
      end
      m_adc_rst = !(m_busy && (cyc + 1 < m_conv_from));
    end
    chk_en = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("adc_rst", 32'(adc_rst), 32'(m_adc_rst));
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0)   check("out_data", 32'(out_data), 32'(mq[0]));
      else if (m_zero_head) check("out_data_rst", 32'(out_data), 32'd0);
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("timeout_err", 32'(timeout_err), 32'(m_to));
      check("sample_count", 32'(sample_count), 32'(m_count));
    end
  end

  int n_low = 0, n_fall = 0;
  logic mon_prev = 1'b0;
  always @(negedge clk) begin
    if (adc_rst === 1'b0) n_low++;
    if (mon_prev === 1'b1 && adc_rst === 1'b0) n_fall++;
    mon_prev = adc_rst;
  end

  initial begin : stim
    int n;
    rst = 1'b0; enable = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_adc_rst", 32'(adc_rst), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(sample_count), 32'd0);
    check("rst_flags", 32'({overflow, timeout_err}), 32'd0);

`ifdef SAMPLE_AVG_EN
    rst = 1'b1; enable = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) vals.push_back(12'(100 * i));
    repeat (2300) @(negedge clk);
    check("avg_count", 32'(sample_count), 32'd2);
    check("avg_first", 32'(out_data), 32'd250);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("avg_second", 32'(out_data), 32'd350);
    enable = 1'b0; out_ready = 1'b1;
    repeat (400) @(negedge clk);
`else
    // Basic capture: fixed sample, consumer always ready
    rst = 1'b1; enable = 1'b1;
    repeat (2) @(negedge clk);
    n_low = 0; n_fall = 0;
    wait_sig(1, 1'b1, 800, "basic_valid", n);
    check("basic_data", 32'(out_data), 32'h0A5C);
    repeat (1500 - n - 2) @(negedge clk);
    check("basic_count", 32'(sample_count), 32'd3);
    check("basic_pulses", 32'(n_fall), 32'd3);
    check("basic_low_cycles", 32'(n_low), 32'd12);

    // Backpressure: 17 conversions into a 16-deep FIFO
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 17; i++) vals.push_back(12'(i));
    repeat (7100) @(negedge clk);
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_count", 32'(sample_count), 32'd16);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_head", 32'(out_data), 32'h001);
    enable = 1'b0; out_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Timeout: reader never completes
    hang = 1'b1; enable = 1'b1;
    wait_sig(0, 1'b0, 500, "to_restart", n);
    wait_sig(0, 1'b1, 10, "to_convert", n);
    wait_sig(2, 1'b1, TO + 50, "to_flag", n);
    check("to_latency", 32'(n), 32'(TO));
    check("to_no_write", 32'(sample_count), 32'd16);
    hang = 1'b0;
    repeat (640) @(negedge clk);
    check("to_recover", 32'(sample_count), 32'd17);
    check("to_sticky", 32'(timeout_err), 32'd1);

    // Enable drop mid-conversion
    enable = 1'b0; out_ready = 1'b0;
    n_fall = 0;
    repeat (600) @(negedge clk);
    check("drop_count", 32'(sample_count), 32'd18);
    check("drop_no_pulse", 32'(n_fall), 32'd0);
    check("drop_head", 32'(out_data), 32'h011);

    // Reset during CONVERT
    enable = 1'b1;
    wait_sig(0, 1'b0, 500, "rm_restart", n);
    wait_sig(0, 1'b1, 10, "rm_convert", n);
    repeat (30) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rm_valid", 32'(out_valid), 32'd0);
    check("rm_adc_rst", 32'(adc_rst), 32'd0);
    check("rm_flags", 32'({overflow, timeout_err}), 32'd0);
    check("rm_count", 32'(sample_count), 32'd0);
    rst = 1'b1; enable = 1'b0;
    repeat (400) @(negedge clk);
    check("rm_no_stray", 32'(sample_count), 32'd0);
    check("rm_empty", 32'(out_valid), 32'd0);
`endif

    // Random samples and random consumer stalls
    enable = 1'b1; rand_vals = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
    end
    enable = 1'b0; out_ready = 1'b1;
    repeat (400) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit expired");
  end

endmodule
